// File: rtl/io_pkg.sv
// Shared definitions for the I/O port bridge: byte width and the
// interrupt-request FSM state encoding.
package io_pkg;

    localparam int IO_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_RD = 2'd2
    } int_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock byte FIFO. Push is refused when full (even if a pop happens
// in the same cycle), pop is ignored when empty, and the head entry is
// presented combinationally (zero when empty). DEPTH must be a power of
// two so the pointers wrap naturally.
module io_sync_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = IO_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Head byte, forced to zero while the FIFO holds nothing.
    always_comb begin
        head = {W{1'b0}};
        if (!empty) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = {W{1'b0}};
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// Peripheral-side partner of the CPU wrapper's I/O pins. Buffers producer
// bytes for the CPU's IN instruction, requests service through int_sig,
// and forwards bytes written by OUT to a valid/ready consumer.
module io_port_bridge
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int INT_PULSE  = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  ext_in_data,
    input  logic        ext_in_valid,
    output logic        ext_in_ready,
    output logic [7:0]  cpu_in_port,
    input  logic        cpu_in_rd,
    output logic        int_sig,
    input  logic [7:0]  cpu_out_port,
    input  logic        cpu_out_wr,
    output logic [7:0]  ext_out_data,
    output logic        ext_out_valid,
    input  logic        ext_out_ready,
    output logic        in_underrun,
    output logic        out_overrun
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
    localparam logic [PW-1:0] PULSE_LOAD = PW'(INT_PULSE - 1);

    logic [CW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    int_state_e    state_r;
    int_state_e    state_nxt_s;
    logic [PW-1:0] pulse_r;
    logic [PW-1:0] pulse_nxt_s;
    logic          int_sig_r;
    logic [7:0]    out_data_r;
    logic          out_valid_r;
    logic          underrun_r;
    logic          overrun_r;

    assign ext_in_ready = !full_s;
    assign push_s       = ext_in_valid && !full_s;

    io_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IO_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .wdata (ext_in_data),
        .pop   (cpu_in_rd),
        .head  (cpu_in_port),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Interrupt FSM next state: raise a fixed-length request whenever data
    // is waiting, then hold off until the CPU reads.
    always_comb begin
        state_nxt_s = state_r;
        pulse_nxt_s = pulse_r;
        case (state_r)
            IDLE: begin
                if (count_s != {CW{1'b0}}) begin
                    state_nxt_s = ASSERT;
                    pulse_nxt_s = PULSE_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ASSERT: begin
                if (cpu_in_rd) begin
                    state_nxt_s = IDLE;
                end else if (pulse_r == {PW{1'b0}}) begin
                    state_nxt_s = WAIT_RD;
                end else begin
                    pulse_nxt_s = pulse_r - PW'(1'b1);
                end
            end
            WAIT_RD: begin
                if (cpu_in_rd) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pulse_nxt_s = {PW{1'b0}};
            end
        endcase
    end

    // Interrupt FSM state, pulse counter and the registered request line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            pulse_r   <= {PW{1'b0}};
            int_sig_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pulse_r   <= pulse_nxt_s;
            int_sig_r <= (state_r == ASSERT);
        end
    end

    // Output byte register with valid/ready hand-off to the consumer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
        end else if (cpu_out_wr) begin
            out_data_r  <= cpu_out_port;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && ext_out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Sticky error flags; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (cpu_in_rd && empty_s) begin
                underrun_r <= 1'b1;
            end
            if (cpu_out_wr && out_valid_r && !ext_out_ready) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign int_sig       = int_sig_r;
    assign ext_out_data  = out_data_r;
    assign ext_out_valid = out_valid_r;
    assign in_underrun   = underrun_r;
    assign out_overrun   = overrun_r;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge: table-driven output-path vectors plus
// hand-written sequences for reset, interrupt timing and FIFO corner cases.
module tb_io_port_bridge;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] ext_in_data;
    logic       ext_in_valid;
    logic       ext_in_ready;
    logic [7:0] cpu_in_port;
    logic       cpu_in_rd;
    logic       int_sig;
    logic [7:0] cpu_out_port;
    logic       cpu_out_wr;
    logic [7:0] ext_out_data;
    logic       ext_out_valid;
    logic       ext_out_ready;
    logic       in_underrun;
    logic       out_overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic [7:0] port;
        logic       ready;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } out_vec_t;

    out_vec_t ovec [11];

    always #5 clk = ~clk;

    io_port_bridge #(.FIFO_DEPTH(4), .INT_PULSE(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .cpu_in_port   (cpu_in_port),
        .cpu_in_rd     (cpu_in_rd),
        .int_sig       (int_sig),
        .cpu_out_port  (cpu_out_port),
        .cpu_out_wr    (cpu_out_wr),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_underrun   (in_underrun),
        .out_overrun   (out_overrun)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ext_in_data   = 8'h00;
        ext_in_valid  = 1'b0;
        cpu_in_rd     = 1'b0;
        cpu_out_port  = 8'h00;
        cpu_out_wr    = 1'b0;
        ext_out_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_level(input logic lvl, input int budget, input string name);
        int n = 0;
        while (int_sig !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(name, {7'd0, int_sig}, {7'd0, lvl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_i [4];
        logic seen;

        ovec[0]  = '{1'b1, 8'h77, 1'b0, 8'h77, 1'b1, 1'b0};
        ovec[1]  = '{1'b0, 8'h00, 1'b0, 8'h77, 1'b1, 1'b0};
        ovec[2]  = '{1'b0, 8'h00, 1'b0, 8'h77, 1'b1, 1'b0};
        ovec[3]  = '{1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0};
        ovec[4]  = '{1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0};
        ovec[5]  = '{1'b1, 8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
        ovec[6]  = '{1'b1, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0};
        ovec[7]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        ovec[8]  = '{1'b1, 8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
        ovec[9]  = '{1'b1, 8'h22, 1'b0, 8'h22, 1'b1, 1'b1};
        ovec[10] = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1};
        exp_i = '{0, 1, 1, 0};

        // ---- reset state ----
        do_reset();
        tick();
        chk("rst_in_ready",  {7'd0, ext_in_ready},  8'h01);
        chk("rst_in_port",   cpu_in_port,           8'h00);
        chk("rst_int",       {7'd0, int_sig},       8'h00);
        chk("rst_out_data",  ext_out_data,          8'h00);
        chk("rst_out_valid", {7'd0, ext_out_valid}, 8'h00);
        chk("rst_flags",     {6'd0, in_underrun, out_overrun}, 8'h00);

        // ---- reset mid-transfer discards data ----
        ext_in_valid = 1'b1; ext_in_data = 8'hA5;
        cpu_out_wr = 1'b1; cpu_out_port = 8'h5A;
        tick();
        idle_inputs();
        chk("mid_in_port", cpu_in_port, 8'hA5);
        chk("mid_out_valid", {7'd0, ext_out_valid}, 8'h01);
        rstn = 1'b0;
        #2;
        chk("async_in_port",   cpu_in_port,           8'h00);
        chk("async_out_valid", {7'd0, ext_out_valid}, 8'h00);
        chk("async_out_data",  ext_out_data,          8'h00);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 1'b0;
        repeat (4) begin tick(); seen |= int_sig; end
        chk("post_rst_in_port", cpu_in_port, 8'h00);
        chk("post_rst_in_ready", {7'd0, ext_in_ready}, 8'h01);
        chk("post_rst_no_int", {7'd0, seen}, 8'h00);

        // ---- single byte: interrupt timing ----
        ext_in_valid = 1'b1; ext_in_data = 8'h3C;
        tick();
        ext_in_valid = 1'b0;
        chk("single_port", cpu_in_port, 8'h3C);
        chk("single_int_n0", {7'd0, int_sig}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("single_int_n%0d", k + 1), {7'd0, int_sig}, 8'(exp_i[k]));
        end
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("single_empty_port", cpu_in_port, 8'h00);
        seen = 1'b0;
        repeat (5) begin tick(); seen |= int_sig; end
        chk("single_no_reint", {7'd0, seen}, 8'h00);
        chk("single_no_underrun", {7'd0, in_underrun}, 8'h00);

        // ---- fill and overflow ----
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            ext_in_valid = 1'b1;
            ext_in_data  = i[7:0];
            chk($sformatf("fill_ready_%0d", i), {7'd0, ext_in_ready}, (i <= 4) ? 8'h01 : 8'h00);
            tick();
        end
        ext_in_valid = 1'b0;
        chk("full_ready", {7'd0, ext_in_ready}, 8'h00);
        chk("full_head", cpu_in_port, 8'h01);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                wait_level(1'b1, 20, "fill_int_reissue");
            end
            wait_level(1'b0, 20, "fill_int_low");
            chk($sformatf("fill_read_%0d", k), cpu_in_port, 8'(k + 1));
            cpu_in_rd = 1'b1;
            tick();
            cpu_in_rd = 1'b0;
        end
        chk("drained_port", cpu_in_port, 8'h00);
        chk("drained_ready", {7'd0, ext_in_ready}, 8'h01);
        seen = 1'b0;
        repeat (6) begin tick(); seen |= int_sig; end
        chk("drained_no_int", {7'd0, seen}, 8'h00);
        chk("fill_no_underrun", {7'd0, in_underrun}, 8'h00);

        // ---- underrun and simultaneous push/pop ----
        do_reset();
        cpu_in_rd = 1'b1;
        tick();
        cpu_in_rd = 1'b0;
        chk("underrun_flag", {7'd0, in_underrun}, 8'h01);
        chk("underrun_port", cpu_in_port, 8'h00);
        chk("underrun_ready", {7'd0, ext_in_ready}, 8'h01);
        ext_in_valid = 1'b1; ext_in_data = 8'hAA; tick();
        ext_in_data = 8'hBB; tick();
        ext_in_valid = 1'b0;
        chk("simul_head_pre", cpu_in_port, 8'hAA);
        ext_in_valid = 1'b1; ext_in_data = 8'hCC; cpu_in_rd = 1'b1;
        tick();
        ext_in_valid = 1'b0; cpu_in_rd = 1'b0;
        chk("simul_head_post", cpu_in_port, 8'hBB);
        cpu_in_rd = 1'b1; tick(); cpu_in_rd = 1'b0;
        chk("simul_second", cpu_in_port, 8'hCC);
        cpu_in_rd = 1'b1; tick(); cpu_in_rd = 1'b0;
        chk("simul_empty", cpu_in_port, 8'h00);
        chk("underrun_sticky", {7'd0, in_underrun}, 8'h01);

        // ---- output path vectors ----
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cpu_out_wr    = ovec[i].wr;
            cpu_out_port  = ovec[i].port;
            ext_out_ready = ovec[i].ready;
            tick();
            chk($sformatf("out_data_%0d", i),  ext_out_data,           ovec[i].exp_data);
            chk($sformatf("out_valid_%0d", i), {7'd0, ext_out_valid},  {7'd0, ovec[i].exp_valid});
            chk($sformatf("out_ovr_%0d", i),   {7'd0, out_overrun},    {7'd0, ovec[i].exp_ovr});
        end
        idle_inputs();
        chk("out_no_underrun", {7'd0, in_underrun}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
